// File: rtl/inv_col_transpose_buf.sv
// Column-in / row-out complex matrix buffer.
// Captures SIZE columns into a SIZE x SIZE register array, then serves whole rows on a
// request/response port until the consumer releases the matrix. No arithmetic is performed.
module inv_col_transpose_buf #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned EW   = 2 * WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [SIZE-1:0][EW-1:0]  col_i,
  input  logic [AW-1:0]            col_addr_i,
  input  logic                     col_valid_i,
  output logic                     col_ready_o,
  output logic                     full_o,
  input  logic                     release_i,
  input  logic [AW-1:0]            row_read_addr_i,
  input  logic                     row_read_valid_i,
  output logic                     row_read_ready_o,
  output logic [SIZE-1:0][EW-1:0]  row_o,
  output logic [AW-1:0]            row_addr_o,
  output logic                     row_valid_o,
  input  logic                     row_out_ready_i
);

  typedef enum logic {StFill, StFull} state_e;

  state_e                r_state;
  logic [SIZE-1:0]       r_written;
  logic [EW-1:0]         r_mem [SIZE][SIZE];
  logic [SIZE-1:0][EW-1:0] r_row;
  logic [AW-1:0]         r_row_addr;
  logic                  r_row_valid;

  logic                  w_col_addr_ok;
  logic                  w_row_addr_ok;
  logic                  w_col_acc;
  logic                  w_rd_acc;
  logic [SIZE-1:0]       w_written_nxt;

  // Address range checks only matter for non-power-of-2 SIZE.
  assign w_col_addr_ok = ({1'b0, col_addr_i} < (AW+1)'(SIZE));
  assign w_row_addr_ok = ({1'b0, row_read_addr_i} < (AW+1)'(SIZE));

  assign col_ready_o      = (r_state == StFill);
  assign full_o           = (r_state == StFull);
  assign row_read_ready_o = full_o && (!r_row_valid || row_out_ready_i);

  assign w_col_acc     = !flush_i && col_valid_i && col_ready_o && w_col_addr_ok;
  assign w_rd_acc      = !flush_i && row_read_valid_i && row_read_ready_o && w_row_addr_ok;
  assign w_written_nxt = r_written | (SIZE'(1) << col_addr_i);

  assign row_o       = r_row;
  assign row_addr_o  = r_row_addr;
  assign row_valid_o = r_row_valid;

  // Storage: an accepted column lands transposed, element k going to row k.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (w_col_acc) begin
      for (int k = 0; k < SIZE; k++) begin
        r_mem[k][col_addr_i] <= col_i[k];
      end
    end
  end

  // Fill/full control, column mask and the registered row output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StFill;
      r_written   <= '0;
      r_row       <= '0;
      r_row_addr  <= '0;
      r_row_valid <= 1'b0;
    end else if (flush_i) begin
      // mem and the last row data are deliberately kept.
      r_state     <= StFill;
      r_written   <= '0;
      r_row_valid <= 1'b0;
    end else begin
      if (r_row_valid && row_out_ready_i) begin
        r_row_valid <= 1'b0;
      end
      case (r_state)
        StFill: begin
          if (w_col_acc) begin
            r_written <= w_written_nxt;
            if (&w_written_nxt) begin
              r_state <= StFull;
            end
          end
        end
        StFull: begin
          if (w_rd_acc) begin
            r_row_valid <= 1'b1;
            r_row_addr  <= row_read_addr_i;
            for (int c = 0; c < SIZE; c++) begin
              r_row[c] <= r_mem[row_read_addr_i][c];
            end
          end
          // Release only once any pending row has been handed over.
          if (release_i && !r_row_valid) begin
            r_state   <= StFill;
            r_written <= '0;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_col_transpose_buf.sv
// Self-checking bench for inv_col_transpose_buf: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_inv_col_transpose_buf;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned AW    = 2;
  localparam int unsigned EW    = 2 * WIDTH;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    flush_i;
  logic [SIZE-1:0][EW-1:0] col_i;
  logic [AW-1:0]           col_addr_i;
  logic                    col_valid_i;
  logic                    col_ready_o;
  logic                    full_o;
  logic                    release_i;
  logic [AW-1:0]           row_read_addr_i;
  logic                    row_read_valid_i;
  logic                    row_read_ready_o;
  logic [SIZE-1:0][EW-1:0] row_o;
  logic [AW-1:0]           row_addr_o;
  logic                    row_valid_o;
  logic                    row_out_ready_i;

  inv_col_transpose_buf #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .col_i           (col_i),
    .col_addr_i      (col_addr_i),
    .col_valid_i     (col_valid_i),
    .col_ready_o     (col_ready_o),
    .full_o          (full_o),
    .release_i       (release_i),
    .row_read_addr_i (row_read_addr_i),
    .row_read_valid_i(row_read_valid_i),
    .row_read_ready_o(row_read_ready_o),
    .row_o           (row_o),
    .row_addr_o      (row_addr_o),
    .row_valid_o     (row_valid_o),
    .row_out_ready_i (row_out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit flush; bit cv; int ca; int ctag; bit rel; bit rv; int ra; bit ordy;
    bit e_full; bit e_cr; bit e_rv; int e_ra; bit e_rrdy;
  } vec_t;

  vec_t vecs[$];

  // Element (r,c): real = 10r+c (+100 per tag), imag = -r, as doubles packed {imag, real}.
  function automatic logic [EW-1:0] elem(int r, int c, int tag);
    return {$realtobits(-real'(r)), $realtobits(real'(10 * r + c + 100 * tag))};
  endfunction

  task automatic chk(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_col(int c, int tag);
    for (int k = 0; k < SIZE; k++) col_i[k] = elem(k, c, tag);
    col_addr_i = AW'(c);
  endtask

  task automatic idle_inputs();
    flush_i = 0; col_valid_i = 0; release_i = 0; row_read_valid_i = 0;
    col_addr_i = '0; row_read_addr_i = '0; col_i = '0;
  endtask

  task automatic chk_row(string name, int r, int tag);
    for (int c = 0; c < SIZE; c++) chk($sformatf("%s_c%0d", name, c), row_o[c], elem(r, c, tag));
  endtask

  task automatic fill_matrix();
    row_out_ready_i = 1;
    for (int c = 0; c < SIZE; c++) begin
      set_col(c, 0); col_valid_i = 1; step();
    end
    col_valid_i = 0;
  endtask

  // Reference model state (transaction level).
  logic [EW-1:0]           m_mem [SIZE][SIZE];
  bit                      m_wr  [SIZE];
  bit                      m_full, m_vld;
  int                      m_addr;
  logic [SIZE-1:0][EW-1:0] m_row;

  task automatic model_reset();
    for (int r = 0; r < SIZE; r++) begin
      m_wr[r] = 0;
      for (int c = 0; c < SIZE; c++) m_mem[r][c] = '0;
    end
    m_full = 0; m_vld = 0; m_addr = 0; m_row = '0;
  endtask

  // Apply one cycle's inputs to the model, using pre-edge state.
  task automatic model_cycle();
    bit rrdy, all_wr;
    bit was_full, was_vld;
    rrdy = m_full && (!m_vld || row_out_ready_i);
    was_full = m_full; was_vld = m_vld;
    if (flush_i) begin
      m_full = 0; m_vld = 0;
      for (int c = 0; c < SIZE; c++) m_wr[c] = 0;
    end else begin
      if (was_vld && row_out_ready_i) m_vld = 0;
      if (!was_full && col_valid_i) begin
        for (int k = 0; k < SIZE; k++) m_mem[k][col_addr_i] = col_i[k];
        m_wr[col_addr_i] = 1;
        all_wr = 1;
        for (int c = 0; c < SIZE; c++) all_wr &= m_wr[c];
        if (all_wr) m_full = 1;
      end
      if (was_full && row_read_valid_i && rrdy) begin
        for (int c = 0; c < SIZE; c++) m_row[c] = m_mem[row_read_addr_i][c];
        m_addr = int'(row_read_addr_i);
        m_vld = 1;
      end
      if (was_full && release_i && !was_vld) begin
        m_full = 0;
        for (int c = 0; c < SIZE; c++) m_wr[c] = 0;
      end
    end
  endtask

  initial begin
    rst_ni = 0;
    row_out_ready_i = 1;
    idle_inputs();

    // flush,cv,ca,ctag,rel,rv,ra,ordy | full,col_ready,row_valid,row_addr,rd_ready
    vecs.push_back('{0,1,0,0,0,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,1,0,0,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,2,0,0,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,3,0,0,0,0,1, 1,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1,2,1, 1,0,1,2,1});
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,0,0,1});
    vecs.push_back('{0,0,0,0,1,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,0,0,0,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,1,1,0,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,1,0,0,0,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,2,0,0,1,0,1, 0,1,0,0,0});
    vecs.push_back('{0,1,3,0,0,0,0,1, 1,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1,0,1, 1,0,1,0,1});
    vecs.push_back('{0,0,0,0,0,0,0,1, 1,0,0,0,1});

    #12;
    chk("rst_col_ready", EW'(col_ready_o), EW'(1));
    chk("rst_full", EW'(full_o), EW'(0));
    chk("rst_row_valid", EW'(row_valid_o), EW'(0));
    chk("rst_rd_ready", EW'(row_read_ready_o), EW'(0));
    chk("rst_row_o", row_o[0], '0);
    step();
    rst_ni = 1;

    // Directed table.
    foreach (vecs[i]) begin
      flush_i = vecs[i].flush; col_valid_i = vecs[i].cv; set_col(vecs[i].ca, vecs[i].ctag);
      release_i = vecs[i].rel; row_read_valid_i = vecs[i].rv;
      row_read_addr_i = AW'(vecs[i].ra); row_out_ready_i = vecs[i].ordy;
      step();
      chk($sformatf("v%0d_full", i), EW'(full_o), EW'(vecs[i].e_full));
      chk($sformatf("v%0d_col_ready", i), EW'(col_ready_o), EW'(vecs[i].e_cr));
      chk($sformatf("v%0d_row_valid", i), EW'(row_valid_o), EW'(vecs[i].e_rv));
      chk($sformatf("v%0d_rd_ready", i), EW'(row_read_ready_o), EW'(vecs[i].e_rrdy));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_row_addr", i), EW'(row_addr_o), EW'(vecs[i].e_ra));
        chk_row($sformatf("v%0d_row", i), vecs[i].e_ra, 0);
      end
    end
    idle_inputs();

    // Stall with row 3 pending: output holds, no new read, release ignored.
    row_out_ready_i = 0; row_read_valid_i = 1; row_read_addr_i = 3;
    step();
    row_read_addr_i = 1; release_i = 1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), EW'(row_valid_o), EW'(1));
      chk($sformatf("stall%0d_addr", i), EW'(row_addr_o), EW'(3));
      chk($sformatf("stall%0d_rd_ready", i), EW'(row_read_ready_o), EW'(0));
      chk($sformatf("stall%0d_full", i), EW'(full_o), EW'(1));
      chk_row($sformatf("stall%0d_row", i), 3, 0);
      step();
    end
    row_out_ready_i = 1; row_read_valid_i = 0; release_i = 0;
    step();
    chk("retire_valid", EW'(row_valid_o), EW'(0));
    chk("retire_full", EW'(full_o), EW'(1));
    release_i = 1; set_col(0, 3); col_valid_i = 1;
    step();
    release_i = 0; col_valid_i = 0;
    chk("release_full", EW'(full_o), EW'(0));
    chk("release_col_ready", EW'(col_ready_o), EW'(1));

    // Column presented in the release cycle must not count: three more columns do not fill.
    for (int c = 1; c < SIZE; c++) begin
      set_col(c, 0); col_valid_i = 1; step();
    end
    col_valid_i = 0;
    chk("relcol_not_written", EW'(full_o), EW'(0));
    set_col(0, 0); col_valid_i = 1; step(); col_valid_i = 0;
    chk("refill_full", EW'(full_o), EW'(1));

    // Column strobe in FULL with all-ones data is ignored.
    for (int k = 0; k < SIZE; k++) col_i[k] = '1;
    col_addr_i = 0; col_valid_i = 1;
    step();
    col_valid_i = 0; row_read_valid_i = 1; row_read_addr_i = 0;
    step();
    row_read_valid_i = 0;
    chk("ignore_col_valid", EW'(row_valid_o), EW'(1));
    chk_row("ignore_col_row0", 0, 0);
    step();

    // Back-to-back reads 3,2,1,0.
    row_read_valid_i = 1;
    for (int i = 0; i < SIZE; i++) begin
      row_read_addr_i = AW'(3 - i);
      step();
      chk($sformatf("b2b%0d_valid", i), EW'(row_valid_o), EW'(1));
      chk($sformatf("b2b%0d_addr", i), EW'(row_addr_o), EW'(3 - i));
      chk($sformatf("b2b%0d_c2", i), row_o[2], elem(3 - i, 2, 0));
    end
    row_read_valid_i = 0;

    // Flush while a row is valid: next state is an empty FILL.
    row_out_ready_i = 0; row_read_valid_i = 1; row_read_addr_i = 1;
    step();
    row_read_valid_i = 0;
    chk("preflush_valid", EW'(row_valid_o), EW'(1));
    flush_i = 1;
    step();
    flush_i = 0; row_out_ready_i = 1;
    chk("flush_valid", EW'(row_valid_o), EW'(0));
    chk("flush_full", EW'(full_o), EW'(0));
    chk("flush_col_ready", EW'(col_ready_o), EW'(1));

    // Asynchronous reset mid-write; row_o still holds row 1 from before the flush.
    set_col(2, 0); col_valid_i = 1;
    #2;
    rst_ni = 0;
    #1;
    chk("arst_row_o", row_o[0], '0);
    chk("arst_row_valid", EW'(row_valid_o), EW'(0));
    chk("arst_col_ready", EW'(col_ready_o), EW'(1));
    chk("arst_full", EW'(full_o), EW'(0));
    idle_inputs();
    step();
    rst_ni = 1;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      flush_i = ($urandom_range(0, 15) == 0);
      col_valid_i = $urandom_range(0, 1);
      col_addr_i = AW'($urandom_range(0, SIZE - 1));
      for (int k = 0; k < SIZE; k++) col_i[k] = {$urandom, $urandom, $urandom, $urandom};
      release_i = ($urandom_range(0, 7) == 0);
      row_read_valid_i = $urandom_range(0, 1);
      row_read_addr_i = AW'($urandom_range(0, SIZE - 1));
      row_out_ready_i = ($urandom_range(0, 3) != 0);
      model_cycle();
      step();
      chk($sformatf("rnd%0d_full", i), EW'(full_o), EW'(m_full));
      chk($sformatf("rnd%0d_col_ready", i), EW'(col_ready_o), EW'(!m_full));
      chk($sformatf("rnd%0d_valid", i), EW'(row_valid_o), EW'(m_vld));
      chk($sformatf("rnd%0d_rd_ready", i), EW'(row_read_ready_o),
          EW'(m_full && (!m_vld || row_out_ready_i)));
      if (m_vld) chk($sformatf("rnd%0d_addr", i), EW'(row_addr_o), EW'(m_addr));
      for (int c = 0; c < SIZE; c++) chk($sformatf("rnd%0d_row_c%0d", i, c), row_o[c], m_row[c]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_col_transpose_buf.md
# inv_col_transpose_buf

Column-in / row-out complex matrix buffer that sits directly downstream of `triang_matrix_inv`. It captures the inverse columns emitted on the `inv_col_*` stream into a SIZE×SIZE register array, then serves whole rows on a request/response port so the following product stage can read the inverse row-major. It performs the column-to-row transpose in storage, holds one full matrix, and refuses new columns until the consumer releases it.

## Interface
Parameters:
- `SIZE`, 4, matrix dimension; row/column address width is `$clog2(SIZE)`.
- `WIDTH`, 64, width of one real or imaginary part (IEEE double). Each element is `2*WIDTH` bits packed `{imag, real}`, with real in the low half.

Ports:
- `clk_i`  in  1  single clock for the whole block; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  synchronous clear of the valid mask, state and pending output.
- `col_i`  in  SIZE×2*WIDTH  column data; `col_i[k]` is the element at row k.
- `col_addr_i`  in  $clog2(SIZE)  column index c.
- `col_valid_i`  in  1  column write strobe.
- `col_ready_o`  out  1  high in FILL state; a column is accepted when `col_valid_i && col_ready_o`.
- `full_o`  out  1  high in FULL state.
- `release_i`  in  1  consumer done; returns the buffer from FULL to FILL.
- `row_read_addr_i`  in  $clog2(SIZE)  requested row r.
- `row_read_valid_i`  in  1  row read request.
- `row_read_ready_o`  out  1  `full_o && (!row_valid_o || row_out_ready_i)`.
- `row_o`  out  SIZE×2*WIDTH  row data; `row_o[c]` is the element at (r, c).
- `row_addr_o`  out  $clog2(SIZE)  row index of `row_o`.
- `row_valid_o`  out  1  output valid; held until `row_out_ready_i`.
- `row_out_ready_i`  in  1  consumer accepts `row_o`.

## Operation
- Storage: `mem[r][c]`, SIZE×SIZE elements of 2*WIDTH bits each; `written[SIZE-1:0]` holds one bit per column.
- States:
  - FILL (after reset): accepted column write sets `mem[k][col_addr_i] <= col_i[k]` for all k, and sets `written[col_addr_i]`.
    - A repeated address overwrites the data; the mask is unchanged.
    - When the write completes the mask (all ones after the update), the next state is FULL.
  - FULL: `col_ready_o=0`; column strobes are ignored, with no write and no error.
    - Accepted read request: `row_o[c] <= mem[row_read_addr_i][c]`, `row_addr_o <= row_read_addr_i`, `row_valid_o <= 1`.
    - Reads are non-destructive; any row may be read any number of times, in any order.
- Read requests in FILL are not accepted (`row_read_ready_o=0`).
- `release_i` in FULL with `row_valid_o=0`:
  - next state is FILL and `written` clears;
  - `mem` contents are retained but are treated as stale.
- `release_i` in FULL with `row_valid_o=1` is ignored, and the consumer must reassert it.
- `release_i` in FILL is ignored.
- `flush_i` has priority over all other inputs: state goes to FILL, `written` clears, `row_valid_o` goes to 0, and `mem` is retained. Other inputs in the same cycle are ignored.
- Out-of-range addresses (possible only for non-power-of-2 SIZE) are dropped, with no write and no read acceptance.
- No arithmetic is performed: data passes bit-exact, and NaN/denormal patterns are untouched.

## Timing
- Reset values, asserted asynchronously on `rst_ni` low: state FILL, `written=0`, `mem=0`, `row_o=0`, `row_addr_o=0`, `row_valid_o=0`, `full_o=0`, `col_ready_o=1`, `row_read_ready_o=0`. Reset mid-operation discards the stored matrix.
- Column write to visible state: 1 cycle. `full_o` rises on the edge that accepts the last missing column, so it is high in the following cycle.
- Read latency: 1 cycle from the accepting edge to `row_valid_o`.
  - Back-to-back reads sustain 1 row/cycle while `row_out_ready_i=1`.
  - While stalled (`row_valid_o && !row_out_ready_i`), `row_o` and `row_addr_o` hold stable and no new request is accepted.
- Simultaneous read acceptance and output handshake in the same cycle: the old row retires and the new row loads; `row_valid_o` stays 1.
- Release: `full_o` falls and `col_ready_o` rises in the cycle after the accepting edge. A column presented in the release cycle is not written.

## Test plan
- SIZE=4. Write columns 0..3 with real part = 10r+c and imag = −r (as doubles), `row_out_ready_i=1`.
  - `full_o` is 1 exactly one cycle after the col 3 write.
  - Read row 2 → next cycle `row_valid_o=1`, `row_addr_o=2`, `row_o[1]={$realtobits(-2.0), $realtobits(21.0)}`.
- Write cols 0,1,1,2: `full_o` stays 0 and row reads are refused. Then write col 3 → `full_o=1`, and row 0 col 1 returns the second col-1 value.
- In FULL, hold `row_out_ready_i=0` with a read of row 3 pending:
  - `row_o`/`row_addr_o` stay stable for 5 cycles;
  - `row_read_ready_o=0` and `release_i` is ignored;
  - raise ready → the row retires, the next release is accepted, and `col_ready_o=1` one cycle later.
- In FULL, drive `col_valid_i` with all-ones data to col 0 → `mem` unchanged; re-read of row 0 returns the original values.
- Back-to-back reads of rows 3,2,1,0 with ready=1 → four consecutive valid cycles with `row_addr_o` 3,2,1,0.
- Assert `flush_i` while `row_valid_o=1` → next cycle `row_valid_o=0`, `full_o=0`, `col_ready_o=1`.
  - Drop `rst_ni` asynchronously mid-write → outputs take their reset values immediately, without waiting for a clock edge.
